// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: receive side of the PS/2 keyboard port.
// Synchronizes the raw PS/2 pins, frames bytes (start, 8 data, odd parity,
// stop, with a timeout), folds E0/F0 prefixes into key events and queues
// those events in a FIFO that the CPU pops through the keyboard register.
module ps2_kbd_ctrl #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ren,
  output logic [15:0] data,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchronizer and edge-history flops
  logic clk_s1_reg, clk_s2_reg, clk_hist_reg;
  logic data_s1_reg, data_s2_reg;
  logic fe;

  // Framing state
  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          par_reg, par_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic          byte_vld_reg, byte_vld_next;
  logic [7:0]    byte_reg;
  logic          frame_bad;

  // Prefix decode
  logic ext_pend_reg, ext_pend_next;
  logic brk_pend_reg, brk_pend_next;
  logic push_evt;
  logic [9:0] push_entry;

  // Event FIFO
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        empty, full, pop, push, ovf_set;
  logic [9:0]  head;

  // Sticky status flags
  logic ovf_reg, ovf_next;
  logic err_reg, err_next;

  // A falling edge is a 1 in history followed by a 0 in the synced flop.
  assign fe = clk_hist_reg & ~clk_s2_reg;

  // Pin synchronizers; all reset to 1 so leaving reset never looks like an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_reg   <= 1'b1;
      clk_s2_reg   <= 1'b1;
      clk_hist_reg <= 1'b1;
      data_s1_reg  <= 1'b1;
      data_s2_reg  <= 1'b1;
    end else begin
      clk_s1_reg   <= ps2_clk;
      clk_s2_reg   <= clk_s1_reg;
      clk_hist_reg <= clk_s2_reg;
      data_s1_reg  <= ps2_data;
      data_s2_reg  <= data_s1_reg;
    end
  end

  // Frame sequencer next-state: advances only on fe, except the timeout abort
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    par_next      = par_reg;
    byte_vld_next = 1'b0;
    frame_bad     = 1'b0;
    if (state_reg == IDLE || fe) tmo_cnt_next = '0;
    else                         tmo_cnt_next = tmo_cnt_reg + TW'(1);

    if (fe) begin
      case (state_reg)
        IDLE: begin
          // A high sample here is just line noise, not an error.
          if (!data_s2_reg) begin
            state_next   = DATA;
            bit_cnt_next = 3'd0;
          end
        end
        DATA: begin
          shift_next   = {data_s2_reg, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          par_next   = data_s2_reg;
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (data_s2_reg && ((^shift_reg) ^ par_reg)) byte_vld_next = 1'b1;
          else                                         frame_bad     = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE && tmo_cnt_reg == TMO_LAST) begin
      state_next   = IDLE;
      tmo_cnt_next = '0;
      frame_bad    = 1'b1;
    end
  end

  // Frame sequencer registers, including the one-cycle accepted-byte strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      par_reg      <= 1'b0;
      tmo_cnt_reg  <= '0;
      byte_vld_reg <= 1'b0;
      byte_reg     <= 8'd0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      par_reg      <= par_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      byte_vld_reg <= byte_vld_next;
      if (byte_vld_next) byte_reg <= shift_reg;
    end
  end

  // Prefix folding: E0/F0 only arm flags, any other byte becomes an event
  always_comb begin
    ext_pend_next = ext_pend_reg;
    brk_pend_next = brk_pend_reg;
    push_evt      = 1'b0;
    push_entry    = {ext_pend_reg, brk_pend_reg, byte_reg};
    if (frame_bad) begin
      ext_pend_next = 1'b0;
      brk_pend_next = 1'b0;
    end else if (byte_vld_reg) begin
      if (byte_reg == 8'hE0) begin
        ext_pend_next = 1'b1;
      end else if (byte_reg == 8'hF0) begin
        brk_pend_next = 1'b1;
      end else begin
        push_evt      = 1'b1;
        ext_pend_next = 1'b0;
        brk_pend_next = 1'b0;
      end
    end
  end

  // FIFO control and sticky flags; a set in the same cycle as ren wins
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop     = ren & ~empty;
  assign push    = push_evt & (~full | pop);
  assign ovf_set = push_evt & full & ~pop;

  always_comb begin
    ovf_next = ovf_set   | (ovf_reg & ~ren);
    err_next = frame_bad | (err_reg & ~ren);
  end

  // Prefix flags, FIFO pointers and sticky status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_pend_reg <= 1'b0;
      brk_pend_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ovf_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      ext_pend_reg <= ext_pend_next;
      brk_pend_reg <= brk_pend_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      ovf_reg      <= ovf_next;
      err_reg      <= err_next;
    end
  end

  // FIFO storage; the head is read combinationally so a pop shows the next
  // entry in the very next cycle
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= push_entry;
  end

  assign head = empty ? 10'd0 : mem[rd_ptr_reg[AW-1:0]];
  assign data = {~empty, ovf_reg, err_reg, 3'b000, head};
  assign irq  = ~empty;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed testbench for ps2_kbd_ctrl: drives PS/2 frames on the pins and
// checks the keyboard register after each step with immediate assertions.
module tb_ps2_kbd_ctrl;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic        ren;
  logic [15:0] data;
  logic        irq;

  int tests = 0;
  int fails = 0;

  ps2_kbd_ctrl #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ren      (ren),
    .data     (data),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Frame bit 0 is start, 1..8 data LSB first, 9 odd parity, 10 stop.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      ps2_data = fr[i];
      repeat (2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_bits(mk_frame(b, bad_par), 0, 11);
    repeat (2) @(negedge clk);
    $display("[TB] sent byte 0x%02h bad_par=%0d data=0x%04h", b, bad_par, data);
  endtask

  task automatic do_ren();
    @(negedge clk) ren = 1'b1;
    @(negedge clk) ren = 1'b0;
    $display("[TB] ren pulse, data=0x%04h", data);
  endtask

  initial begin
    logic [10:0]  fr;
    logic [15:0] exp;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    ren      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", data, 16'h0000);
    check("reset_irq", {15'd0, irq}, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain make code, then pop
    send_byte(8'h1C, 1'b0);
    check("make_1c", data, 16'h801C);
    check("make_irq", {15'd0, irq}, 16'h0001);
    do_ren();
    check("pop_empty", data, 16'h0000);
    check("pop_irq", {15'd0, irq}, 16'h0000);

    // Break and extended-break folding
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check("break_1c", data, 16'h811C);
    do_ren();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("ext_break_75", data, 16'h8375);
    do_ren();
    check("pop_after_ext", data, 16'h0000);
    send_byte(8'hF0, 1'b0);
    check("prefix_only", data, 16'h0000);

    // Parity error discards the byte and clears the pending F0
    send_byte(8'h1C, 1'b1);
    check("parity_err", data, 16'h2000);
    send_byte(8'h1C, 1'b0);
    check("after_parity_err", data, 16'hA01C);
    do_ren();
    check("ren_clears_err", data, 16'h0000);

    // Fill past capacity
    for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i), 1'b0);
    check("overflow", data, 16'hC015);

    // Push coincident with ren while full: stop-bit edge, ren in the push cycle
    fr = mk_frame(8'h1E, 1'b0);
    send_bits(fr, 0, 10);
    ps2_data = 1'b1;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) ren = 1'b1;
    @(negedge clk) ren = 1'b0;
    $display("[TB] sent byte 0x1e with coincident ren, data=0x%04h", data);
    check("full_push_pop", data, 16'h8016);
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2) @(negedge clk);

    // Drain: 0x17..0x1C then 0x1E, then empty
    for (int i = 0; i < 8; i++) begin
      do_ren();
      if (i < 6)       exp = 16'h8017 + 16'(i);
      else if (i == 6) exp = 16'h801E;
      else             exp = 16'h0000;
      check("drain", data, exp);
    end

    // Partial frame then silence: timeout sets the error flag
    send_bits(mk_frame(8'h1C, 1'b0), 0, 5);
    check("partial_no_err", data, 16'h0000);
    repeat (TO + 20) @(negedge clk);
    check("timeout_err", data, 16'h2000);
    send_byte(8'h1C, 1'b0);
    check("after_timeout", data, 16'hA01C);
    do_ren();
    check("after_timeout_pop", data, 16'h0000);

    // Reset mid-frame with two events queued
    send_byte(8'h15, 1'b0);
    send_byte(8'h16, 1'b0);
    check("two_queued", data, 16'h8015);
    fr = mk_frame(8'h1C, 1'b0);
    send_bits(fr, 0, 4);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("midframe_reset", data, 16'h0000);
    send_bits(fr, 4, 7);
    repeat (TO + 20) @(negedge clk);
    check("residual_bits", data, 16'h2000);
    send_byte(8'h1C, 1'b0);
    check("clean_after_reset", data, 16'hA01C);
    do_ren();
    check("final_pop", data, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
